// File: rtl/pomo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pomo_pkg                                                           |
// | Shared types and constants for the pomodoro display/alarm blocks.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pomo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARN  = 2'd1,
    ALARM = 2'd2,
    PAUSE = 2'd3
  } alarm_state_t;

  localparam logic [15:0] BCD_ZERO_16 = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_prescaler                                                     |
// | Free-running 0..DIV-1 counter; tick pulses on the wrap cycle.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/alarm_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alarm_sequencer                                                    |
// | Drives the DP-cathode alarm indicator from the BCD countdown:      |
// | warning flashes near zero, repeating bursts at expiry until lever. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alarm_sequencer
  import pomo_pkg::*;
#(
  parameter int          TICK_DIV      = 25_000_000,
  parameter int          BURST_TOGGLES = 16,
  parameter int          PAUSE_TICKS   = 4,
  parameter logic [7:0]  WARN_SECS     = 8'h10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic       lever,
  output logic       alarm_out,
  output logic       alarm_active
);

  localparam int TOG_W = $clog2(BURST_TOGGLES + 1);
  localparam int PAU_W = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;
  localparam logic [TOG_W-1:0] c_tog_last = TOG_W'(BURST_TOGGLES - 1);
  localparam logic [PAU_W-1:0] c_pau_last = PAU_W'(PAUSE_TICKS - 1);

  alarm_state_t     r_state;
  alarm_state_t     w_state_next;
  logic [15:0]      r_time_q;
  logic [TOG_W-1:0] r_toggle_cnt;
  logic [TOG_W-1:0] w_toggle_cnt_next;
  logic [PAU_W-1:0] r_pause_cnt;
  logic [PAU_W-1:0] w_pause_cnt_next;
  logic             r_alarm_out;
  logic             w_alarm_out_next;
  logic             r_alarm_active;
  logic             w_flash_start;
  logic             w_clr;
  logic             w_tick;
  logic [15:0]      w_live;
  logic             w_expiry;
  logic             w_in_warn;
  logic             w_sec_chg;

  assign w_live    = {min_bcd, sec_bcd};
  // Requiring a nonzero previous value keeps a power-up 00:00 display silent.
  assign w_expiry  = (r_time_q != BCD_ZERO_16) && (w_live == BCD_ZERO_16);
  assign w_in_warn = (min_bcd == 8'h00) && (sec_bcd != 8'h00) && (sec_bcd <= WARN_SECS);
  assign w_sec_chg = (sec_bcd != r_time_q[7:0]);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_next      = r_state;
    w_alarm_out_next  = r_alarm_out;
    w_toggle_cnt_next = r_toggle_cnt;
    w_pause_cnt_next  = r_pause_cnt;
    w_flash_start     = 1'b0;

    case (r_state)
      IDLE: begin
        w_alarm_out_next = 1'b0;
        if (w_expiry) begin
          w_state_next      = ALARM;
          w_alarm_out_next  = 1'b1;
          w_toggle_cnt_next = '0;
        end else if (w_in_warn) begin
          // The second that crosses the threshold gets its flash immediately.
          w_state_next     = WARN;
          w_alarm_out_next = w_sec_chg;
          w_flash_start    = w_sec_chg;
        end
      end

      WARN: begin
        if (w_expiry) begin
          w_state_next      = ALARM;
          w_alarm_out_next  = 1'b1;
          w_toggle_cnt_next = '0;
        end else if (!w_in_warn) begin
          w_state_next     = IDLE;
          w_alarm_out_next = 1'b0;
        end else if (w_sec_chg) begin
          w_alarm_out_next = 1'b1;
          w_flash_start    = 1'b1;
        end else if (w_tick) begin
          w_alarm_out_next = 1'b0;
        end
      end

      ALARM: begin
        if (lever) begin
          w_state_next     = IDLE;
          w_alarm_out_next = 1'b0;
        end else if (w_tick) begin
          if (r_toggle_cnt == c_tog_last) begin
            w_state_next     = PAUSE;
            w_alarm_out_next = 1'b0;
            w_pause_cnt_next = '0;
          end else begin
            w_alarm_out_next  = ~r_alarm_out;
            w_toggle_cnt_next = r_toggle_cnt + TOG_W'(1);
          end
        end
      end

      PAUSE: begin
        w_alarm_out_next = 1'b0;
        if (lever) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          if (r_pause_cnt == c_pau_last) begin
            w_state_next      = ALARM;
            w_alarm_out_next  = 1'b1;
            w_toggle_cnt_next = '0;
          end else begin
            w_pause_cnt_next = r_pause_cnt + PAU_W'(1);
          end
        end
      end

      default: begin
        w_state_next     = IDLE;
        w_alarm_out_next = 1'b0;
      end
    endcase
  end

  // Every phase starts from a fresh prescaler so its first tick is a full period away.
  assign w_clr = (w_state_next != r_state) || w_flash_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_time_q       <= BCD_ZERO_16;
      r_toggle_cnt   <= '0;
      r_pause_cnt    <= '0;
      r_alarm_out    <= 1'b0;
      r_alarm_active <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_time_q       <= w_live;
      r_toggle_cnt   <= w_toggle_cnt_next;
      r_pause_cnt    <= w_pause_cnt_next;
      r_alarm_out    <= w_alarm_out_next;
      r_alarm_active <= (w_state_next == ALARM) || (w_state_next == PAUSE);
    end
  end

  assign alarm_out    = r_alarm_out;
  assign alarm_active = r_alarm_active;

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alarm_sequencer                                                 |
// | Scenario tasks plus random stimulus against an elapsed-time model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_alarm_sequencer;

  localparam int         TD = 4;
  localparam int         BT = 4;
  localparam int         PT = 2;
  localparam logic [7:0] WS = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] min_bcd = 8'h00;
  logic [7:0] sec_bcd = 8'h00;
  logic       lever = 1'b0;
  logic       alarm_out;
  logic       alarm_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_sequencer #(
    .TICK_DIV      (TD),
    .BURST_TOGGLES (BT),
    .PAUSE_TICKS   (PT),
    .WARN_SECS     (WS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .min_bcd      (min_bcd),
    .sec_bcd      (sec_bcd),
    .lever        (lever),
    .alarm_out    (alarm_out),
    .alarm_active (alarm_active)
  );

  // Reference model: alarm phase derived from cycles since expiry,
  // warning flash derived from cycles since the last seconds change.
  bit          m_alarm;
  bit          m_warn;
  int          m_el;
  int          m_fage;
  logic [15:0] m_prev;
  logic [15:0] m_cur;
  bit          m_exp;
  bit          m_iw;

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit exp_out();
    int p;
    if (m_alarm) begin
      p = m_el % ((BT + PT) * TD);
      return (p < BT * TD) && (((p / TD) % 2) == 0);
    end
    return m_warn && (m_fage < TD);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alarm = 0; m_warn = 0; m_el = 0; m_fage = 1000; m_prev = 16'h0000;
    end else begin
      m_cur = {min_bcd, sec_bcd};
      m_exp = (m_prev != 16'h0000) && (m_cur == 16'h0000);
      m_iw  = (min_bcd == 8'h00) && (bcd_val(sec_bcd) >= 1) && (bcd_val(sec_bcd) <= bcd_val(WS));
      if (m_alarm) begin
        if (lever) m_alarm = 0;
        else m_el++;
      end else if (m_exp) begin
        m_alarm = 1; m_el = 0; m_warn = 0; m_fage = 1000;
      end else if (m_iw) begin
        m_warn = 1;
        if (sec_bcd != m_prev[7:0]) m_fage = 0;
        else if (m_fage < 1000) m_fage++;
      end else begin
        m_warn = 0; m_fage = 1000;
      end
      m_prev = m_cur;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; min_bcd = 8'h00; sec_bcd = 8'h00; lever = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (alarm_out !== 1'b0 || alarm_active !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: out=%b active=%b, required 0/0", c, alarm_out, alarm_active);
      end
    end
  endtask

  task automatic test_expiry_burst();
    {min_bcd, sec_bcd} = 16'h0001;
    @(negedge clk);
    {min_bcd, sec_bcd} = 16'h0000;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if (alarm_out !== exp_out() || alarm_active !== m_alarm) begin
        errors++;
        $display("FAIL burst cyc=%0d: out=%b active=%b, required %b/%b", c, alarm_out, alarm_active, exp_out(), m_alarm);
      end
      if (c == 0) begin
        checks++;
        if (alarm_out !== 1'b1 || alarm_active !== 1'b1) begin
          errors++;
          $display("FAIL expiry_latency: out=%b active=%b, required 1/1", alarm_out, alarm_active);
        end
      end
    end
  endtask

  task automatic test_ack();
    lever = 1'b1;
    @(negedge clk);
    lever = 1'b0;
    checks++;
    if (alarm_out !== 1'b0 || alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL ack_edge: out=%b active=%b, required 0/0", alarm_out, alarm_active);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (alarm_out !== 1'b0 || alarm_active !== 1'b0) begin
        errors++;
        $display("FAIL ack_no_retrigger cyc=%0d: out=%b active=%b, required 0/0", c, alarm_out, alarm_active);
      end
    end
  endtask

  task automatic test_warn();
    logic [15:0] seq [4];
    int          want [4];
    int          highs;
    seq  = '{16'h0011, 16'h0010, 16'h0009, 16'h0500};
    want = '{0, TD, TD, 0};
    for (int s = 0; s < 4; s++) begin
      {min_bcd, sec_bcd} = seq[s];
      highs = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        highs += int'(alarm_out);
        checks++;
        if (alarm_out !== exp_out() || alarm_active !== m_alarm) begin
          errors++;
          $display("FAIL warn_model t=%h cyc=%0d: out=%b active=%b, required %b/%b", seq[s], c, alarm_out, alarm_active, exp_out(), m_alarm);
        end
      end
      checks++;
      if (highs != want[s]) begin
        errors++;
        $display("FAIL warn_flash_len t=%h: high cycles=%0d, required %0d", seq[s], highs, want[s]);
      end
    end
  endtask

  task automatic test_lever_expiry();
    {min_bcd, sec_bcd} = 16'h0001;
    repeat (3) @(negedge clk);
    {min_bcd, sec_bcd} = 16'h0000;
    lever = 1'b1;
    @(negedge clk);
    lever = 1'b0;
    checks++;
    if (alarm_active !== 1'b1 || alarm_out !== 1'b1) begin
      errors++;
      $display("FAIL lever_vs_expiry: out=%b active=%b, required 1/1", alarm_out, alarm_active);
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (alarm_out !== exp_out() || alarm_active !== m_alarm) begin
        errors++;
        $display("FAIL lever_expiry_burst cyc=%0d: out=%b active=%b, required %b/%b", c, alarm_out, alarm_active, exp_out(), m_alarm);
      end
    end
    lever = 1'b1;
    @(negedge clk);
    lever = 1'b0;
    checks++;
    if (alarm_out !== 1'b0 || alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL later_ack: out=%b active=%b, required 0/0", alarm_out, alarm_active);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 0;
    {min_bcd, sec_bcd} = 16'h0001;
    @(negedge clk);
    {min_bcd, sec_bcd} = 16'h0000;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (alarm_out === 1'b1 && c > TD) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_setup: alarm_out never high mid-burst within 50 cycles, required 1");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (alarm_out !== 1'b0 || alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%b active=%b before next edge, required 0/0", alarm_out, alarm_active);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (alarm_out !== 1'b0 || alarm_active !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_zero cyc=%0d: out=%b active=%b, required 0/0", c, alarm_out, alarm_active);
      end
    end
  endtask

  task automatic test_random();
    int          r;
    int          hold;
    logic [15:0] v;
    for (int s = 0; s < 300; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        v = 16'h0000;
      end else if (r < 7) begin
        r = int'($urandom_range(0, 12));
        v = {8'h00, 4'(r / 10), 4'(r % 10)};
      end else begin
        v = {4'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      end
      {min_bcd, sec_bcd} = v;
      hold = int'($urandom_range(1, 8));
      for (int c = 0; c < hold; c++) begin
        lever = (c == 0) && ($urandom_range(0, 5) == 0);
        @(negedge clk);
        checks++;
        if (alarm_out !== exp_out() || alarm_active !== m_alarm) begin
          errors++;
          $display("FAIL random seg=%0d t=%h: out=%b active=%b, required %b/%b", s, v, alarm_out, alarm_active, exp_out(), m_alarm);
        end
      end
      lever = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_expiry_burst();
    test_ack();
    test_warn();
    test_lever_expiry();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
